bv8_back_basis_arbiter: RTL and testbench
=========================================

# bv8_back_basis_arbiter

Two-requester, pipelined scheduler that shares one masked back-basis-change stage (the 8-bit linear map applied after the S-box inversion) between the round-state datapath and the key-schedule datapath. Each requester hands over share-wise 8-bit bytes with a valid/ready handshake. Bursts are held atomically, and otherwise the stage is granted round-robin. Each transformed byte is returned through a single registered output tagged with its source, so one basis-change instance serves the whole S-box back end.

## Interface
- N_SHARES, default 2: number of Boolean shares per byte; the data width is 8*N_SHARES.
- MAX_BURST, default 4: maximum number of bytes allowed in one locked burst.
- in_clock  input  1  clock; all state updates on the rising edge.
- in_reset_n  input  1  one clock; reset is asynchronous and active-low.
- in_r0_valid  input  1  state-datapath requester has a byte.
- in_r0_data  input  8*N_SHARES  state-datapath byte; share i in bits [8i+7:8i].
- in_r0_tag  input  4  opaque byte index, returned unchanged.
- in_r0_last  input  1  last byte of the r0 burst.
- out_r0_ready  output  1  r0 byte accepted this cycle.
- in_r1_valid, in_r1_data, in_r1_tag, in_r1_last, out_r1_ready: same as the r0 signals, for the key-schedule requester.
- out_valid  output  1  output register holds a result.
- out_data  output  8*N_SHARES  transformed shares.
- out_src  output  1  source of the result: 0 = r0, 1 = r1.
- out_tag  output  4  tag of the accepted byte.
- out_burst_err  output  1  sticky error flag; a burst exceeded MAX_BURST.
- in_ready  input  1  downstream is accepting out_*.

## Operation
- Transform: each share is mapped independently by the back-basis-change linear map. The map is linear, so the XOR of the output shares equals the map of the XOR of the input shares. Shares are never combined.
- Stage free: `free = !out_valid || in_ready`. No byte is accepted unless the stage is free.
- FSM states:
  - RR: round-robin arbitration.
  - LOCK0: burst from r0 in progress.
  - LOCK1: burst from r1 in progress.
- In RR with the stage free:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - After reset `last_grant = 1`, so r0 wins the first tie.
  - If the granted byte has last=0, enter LOCKx, where x is the granted requester.
- In LOCKx: only requester x can be granted. When the granted byte has last=1, return to RR.
- Stalls: with the stage not free, no grant is made and the state is held.
- Grant: out_rX_ready is high combinationally in the grant cycle; the other requester's ready is low. `last_grant` updates to X.
- Burst counter:
  - 3-bit counter, cleared on entering RR and incremented on each grant.
  - If a grant would make the count exceed MAX_BURST, set out_burst_err (sticky until reset) and force the FSM to RR after that grant.
- No combinational path from in_rX_valid to out_valid.

## Timing
- Latency: the byte accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
- Throughput: 1 byte per cycle while in_ready=1.
- Backpressure:
  - With in_ready=0 and out_valid=1, out_* hold their values and both readies stay low.
  - out_data must not change while out_valid=1 && !in_ready.
- Same-edge hand-off: with out_valid=1 and in_ready=1 on the same edge, the old result drains and the new byte loads, giving no bubble.
- Reset values (asserted asynchronously, with no clock needed): out_valid=0, out_data=0, out_src=0, out_tag=0, out_burst_err=0, FSM=RR, last_grant=1, burst counter=0.
- Readies are 0 while in_reset_n=0.
- Reset asserted mid-burst: the result in flight is discarded; after release, arbitration restarts in RR.
- A requester may drop valid inside a locked burst; the lock is held until its last byte is granted. The other requester starves until then, by design.

## Test plan
- Single byte, r0: N_SHARES=2, shares 0x01 and 0x80, last=1, tag 5 -> out_valid one cycle later with shares 0x24 and 0x58 (XOR 0x7C = map(0x81)), out_src=0, out_tag=5. Input 0x00 -> 0x00.
- Tie and round-robin: r0 and r1 both continuously valid with last=1 and in_ready=1 -> grants follow r0, r1, r0, r1, with r0 first after reset; one result every cycle.
- Burst lock: r1 sends 4 bytes (last only on the 4th) while r0 is valid throughout -> r1 is granted 4 consecutive times, r0 on the 5th cycle; out_burst_err stays 0.
- Backpressure: in_ready=0 for 3 cycles with out_valid=1 -> out_* stable; both readies low; no byte lost or duplicated after in_ready returns to 1.
- Burst overflow: r0 sends 5 bytes with last=0 -> out_burst_err=1 after the 5th grant; FSM back in RR, so r1 is granted next if valid; the flag stays set until reset.
- Async reset mid-burst: assert in_reset_n=0 between clock edges during an LOCK1 burst -> out_valid=0 immediately; after release, r0 wins the first tie.

Source files
------------

// File: rtl/bv8_back_basis_arbiter.sv
// bv8_back_basis_arbiter
//
// Shares one masked back-basis-change stage (the 8-bit linear map applied after
// the S-box inversion) between two requesters: r0 (round-state datapath) and
// r1 (key-schedule datapath). Bursts (bytes up to and including one with last=1)
// are granted atomically; otherwise the stage is granted round-robin. Every
// transformed byte lands in a single output register tagged with its source.
//
// Ports
//   in_clock, in_reset_n           clock, asynchronous active-low reset
//   in_rX_valid/data/tag/last      requester X byte offer (X = 0, 1)
//   out_rX_ready                   requester X byte accepted this cycle
//   out_valid/data/src/tag         registered result, source and tag
//   out_burst_err                  sticky: a burst ran past MAX_BURST bytes
//   in_ready                       downstream accepts out_*
//
// Each share is mapped on its own; because the map is linear, the XOR of the
// output shares equals the map of the unmasked byte and shares never combine.

module bv8_back_basis_arbiter #(
  parameter int unsigned N_SHARES  = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,

  input  logic                  in_r0_valid,
  input  logic [8*N_SHARES-1:0] in_r0_data,
  input  logic [3:0]            in_r0_tag,
  input  logic                  in_r0_last,
  output logic                  out_r0_ready,

  input  logic                  in_r1_valid,
  input  logic [8*N_SHARES-1:0] in_r1_data,
  input  logic [3:0]            in_r1_tag,
  input  logic                  in_r1_last,
  output logic                  out_r1_ready,

  output logic                  out_valid,
  output logic [8*N_SHARES-1:0] out_data,
  output logic                  out_src,
  output logic [3:0]            out_tag,
  output logic                  out_burst_err,
  input  logic                  in_ready
);

  localparam int unsigned DataWidth = 8 * N_SHARES;

  typedef enum logic [1:0] {
    StRr    = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } state_e;

  // Back-basis-change matrix, applied column-wise: input bit b contributes the
  // column constant below. Linear only; the affine constant lives elsewhere.
  function automatic logic [7:0] back_basis(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    if (x[7]) y = y ^ 8'h58;
    if (x[6]) y = y ^ 8'h2D;
    if (x[5]) y = y ^ 8'h9E;
    if (x[4]) y = y ^ 8'h0B;
    if (x[3]) y = y ^ 8'hDC;
    if (x[2]) y = y ^ 8'h04;
    if (x[1]) y = y ^ 8'h03;
    if (x[0]) y = y ^ 8'h24;
    return y;
  endfunction

  // Control state
  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [2:0]           count_q, count_d;
  logic                 burst_err_q, burst_err_d;

  // Output register
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 src_q, src_d;
  logic [3:0]           tag_q, tag_d;

  // Grant decode
  logic                 stage_free;
  logic                 gnt0, gnt1, gnt_any;
  logic                 sel_last;
  logic [3:0]           count_inc;
  logic                 burst_over;
  logic [DataWidth-1:0] sel_data;
  logic [DataWidth-1:0] xform;

  always_comb begin
    stage_free = !valid_q || in_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (stage_free) begin
      case (state_q)
        StRr: begin
          if (in_r0_valid && in_r1_valid) begin
            // Tie goes to whoever was not granted last.
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
          end else begin
            gnt0 = in_r0_valid;
            gnt1 = in_r1_valid;
          end
        end
        StLock0: gnt0 = in_r0_valid;
        StLock1: gnt1 = in_r1_valid;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
    gnt_any = gnt0 || gnt1;
  end

  // Readies are forced low while reset is held.
  assign out_r0_ready = gnt0 && in_reset_n;
  assign out_r1_ready = gnt1 && in_reset_n;

  // Next state: FSM, round-robin pointer, burst counter, error flag
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    burst_err_d  = burst_err_q;

    sel_last   = gnt1 ? in_r1_last : in_r0_last;
    count_inc  = {1'b0, count_q} + 4'd1;
    burst_over = (32'(count_inc) > MAX_BURST);

    if (gnt_any) begin
      last_grant_d = gnt1;
      if (burst_over) begin
        burst_err_d = 1'b1;
      end
      // An overlong burst is cut off: the lock is dropped after this grant.
      if (sel_last || burst_over) begin
        state_d = StRr;
        count_d = 3'd0;
      end else begin
        state_d = gnt1 ? StLock1 : StLock0;
        count_d = count_inc[2:0];
      end
    end
  end

  // Datapath: share-wise transform of the granted byte
  always_comb begin
    sel_data = gnt1 ? in_r1_data : in_r0_data;
    xform    = '0;
    for (int i = 0; i < int'(N_SHARES); i++) begin
      xform[8*i +: 8] = back_basis(sel_data[8*i +: 8]);
    end
  end

  // Output register next state: load on grant, drain on in_ready, else hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    tag_d   = tag_q;
    if (gnt_any) begin
      valid_d = 1'b1;
      data_d  = xform;
      src_d   = gnt1;
      tag_d   = gnt1 ? in_r1_tag : in_r0_tag;
    end else if (in_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q      <= StRr;
      last_grant_q <= 1'b1;
      count_q      <= 3'd0;
      burst_err_q  <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      src_q        <= 1'b0;
      tag_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      burst_err_q  <= burst_err_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      src_q        <= src_d;
      tag_q        <= tag_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_src       = src_q;
  assign out_tag       = tag_q;
  assign out_burst_err = burst_err_q;

  // Structural invariants
  a_one_ready : assert property (@(posedge in_clock) disable iff (!in_reset_n)
    !(out_r0_ready && out_r1_ready));

  a_stall_hold : assert property (@(posedge in_clock) disable iff (!in_reset_n)
    (out_valid && !in_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)
                                  && $stable(out_src)));

endmodule

// File: tb/tb_bv8_back_basis_arbiter.sv
module tb_bv8_back_basis_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_last, r0_ready;
  logic [15:0] r0_data;
  logic [3:0]  r0_tag;
  logic        r1_valid, r1_last, r1_ready;
  logic [15:0] r1_data;
  logic [3:0]  r1_tag;
  logic        o_valid, o_src, o_err, ds_ready;
  logic [15:0] o_data;
  logic [3:0]  o_tag;

  int checks   = 0;
  int failures = 0;

  // Hand-computed images: share0 in [7:0], share1 in [15:8]
  localparam logic [15:0] Y0402 = 16'h0403;  // 0x02->0x03, 0x04->0x04
  localparam logic [15:0] Y2010 = 16'h9E0B;  // 0x10->0x0B, 0x20->0x9E
  localparam logic [15:0] Y8001 = 16'h5824;  // 0x01->0x24, 0x80->0x58
  localparam logic [15:0] YFF03 = 16'h1F27;  // 0x03->0x27, 0xFF->0x1F

  always #5 clk = ~clk;

  bv8_back_basis_arbiter #(
    .N_SHARES (2),
    .MAX_BURST(4)
  ) dut (
    .in_clock     (clk),
    .in_reset_n   (rst_n),
    .in_r0_valid  (r0_valid),
    .in_r0_data   (r0_data),
    .in_r0_tag    (r0_tag),
    .in_r0_last   (r0_last),
    .out_r0_ready (r0_ready),
    .in_r1_valid  (r1_valid),
    .in_r1_data   (r1_data),
    .in_r1_tag    (r1_tag),
    .in_r1_last   (r1_last),
    .out_r1_ready (r1_ready),
    .out_valid    (o_valid),
    .out_data     (o_data),
    .out_src      (o_src),
    .out_tag      (o_tag),
    .out_burst_err(o_err),
    .in_ready     (ds_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [15:0] d, input logic [3:0] t, input logic l);
    r0_valid = v; r0_data = d; r0_tag = t; r0_last = l;
  endtask

  task automatic drv1(input logic v, input logic [15:0] d, input logic [3:0] t, input logic l);
    r1_valid = v; r1_data = d; r1_tag = t; r1_last = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                         input logic s, input logic [3:0] t);
    chk({tag, "_valid"}, o_valid, v);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_src"}, o_src, s);
    chk({tag, "_tag"}, o_tag, t);
  endtask

  task automatic chk_rdy(input string tag, input logic e0, input logic e1);
    chk({tag, "_r0_ready"}, r0_ready, e0);
    chk({tag, "_r1_ready"}, r1_ready, e1);
  endtask

  initial begin
    rst_n = 1'b1;
    ds_ready = 1'b1;
    drv0(0, 16'h0, 0, 0);
    drv1(0, 16'h0, 0, 0);

    // Asynchronous reset before any clock edge; readies low even with valids up
    #1 rst_n = 1'b0;
    drv0(1, 16'h0402, 1, 1);
    drv1(1, 16'h2010, 2, 1);
    #1;
    chk_out("rst", 0, 16'h0, 0, 0);
    chk("rst_err", o_err, 0);
    chk_rdy("rst", 0, 0);
    repeat (2) @(negedge clk);
    drv0(0, 16'h0402, 1, 1);
    drv1(0, 16'h2010, 2, 1);
    rst_n = 1'b1;

    // Tie and round-robin: r0 first after reset, then alternation, no bubbles
    @(negedge clk);
    drv0(1, 16'h0402, 1, 1);
    drv1(1, 16'h2010, 2, 1);
    #1 chk_rdy("rr1", 1, 0);
    chk("rr1_valid", o_valid, 0);
    @(negedge clk);
    drv0(1, 16'h0402, 3, 1);
    #1 chk_rdy("rr2", 0, 1);
    chk_out("rr2", 1, Y0402, 0, 1);
    @(negedge clk);
    #1 chk_rdy("rr3", 1, 0);
    chk_out("rr3", 1, Y2010, 1, 2);
    @(negedge clk);
    #1 chk_rdy("rr4", 0, 1);
    chk_out("rr4", 1, Y0402, 0, 3);
    @(negedge clk);
    drv0(0, 16'h0, 0, 0);
    drv1(0, 16'h0, 0, 0);
    #1 chk_out("rr5", 1, Y2010, 1, 2);
    @(negedge clk);

    // Single byte r0: shares 0x01/0x80 -> 0x24/0x58; then zero -> zero
    drv0(1, 16'h8001, 5, 1);
    #1 chk("sb_idle_valid", o_valid, 0);
    chk_rdy("sb1", 1, 0);
    @(negedge clk);
    drv0(1, 16'h0000, 6, 1);
    #1 chk_out("sb2", 1, Y8001, 0, 5);
    @(negedge clk);
    drv0(0, 16'h0, 0, 0);
    #1 chk_out("sb3", 1, 16'h0000, 0, 6);
    @(negedge clk);

    // Burst lock: r1 holds the stage for 4 bytes although r0 is valid
    drv0(1, 16'h0402, 7, 1);
    drv1(1, 16'h2010, 8, 0);
    #1 chk_rdy("bl1", 0, 1);
    @(negedge clk);
    drv1(1, 16'h2010, 9, 0);
    #1 chk_rdy("bl2", 0, 1);
    chk_out("bl2", 1, Y2010, 1, 8);
    @(negedge clk);
    drv1(1, 16'h2010, 10, 0);
    #1 chk_rdy("bl3", 0, 1);
    @(negedge clk);
    drv1(1, 16'h2010, 11, 1);
    #1 chk_rdy("bl4", 0, 1);
    @(negedge clk);
    drv1(0, 16'h2010, 0, 0);
    #1 chk_rdy("bl5", 1, 0);
    chk_out("bl5", 1, Y2010, 1, 11);
    chk("bl5_err", o_err, 0);
    @(negedge clk);

    // Backpressure: 3 stalled cycles, result held, readies low
    drv0(1, 16'hFF03, 12, 1);
    drv1(1, 16'h2010, 13, 1);
    ds_ready = 1'b0;
    #1 chk_out("bp1", 1, Y0402, 0, 7);
    chk_rdy("bp1", 0, 0);
    @(negedge clk);
    #1 chk_out("bp2", 1, Y0402, 0, 7);
    chk_rdy("bp2", 0, 0);
    @(negedge clk);
    #1 chk_out("bp3", 1, Y0402, 0, 7);
    chk_rdy("bp3", 0, 0);
    @(negedge clk);
    ds_ready = 1'b1;
    #1 chk_out("bp4", 1, Y0402, 0, 7);
    chk_rdy("bp4", 0, 1);
    @(negedge clk);
    drv1(0, 16'h0, 0, 0);
    #1 chk_out("bp5", 1, Y2010, 1, 13);
    chk_rdy("bp5", 1, 0);
    @(negedge clk);
    drv0(0, 16'h0, 0, 0);
    #1 chk_out("bp6", 1, YFF03, 0, 12);
    @(negedge clk);

    // Burst overflow: 5 bytes from r0 without last
    for (int i = 0; i < 4; i++) begin
      drv0(1, 16'h0402, 4'(i), 0);
      #1 chk_rdy("ov_lock", 1, 0);
      @(negedge clk);
    end
    drv0(1, 16'h0402, 4, 0);
    drv1(1, 16'h2010, 14, 1);
    #1 chk("ov4_err", o_err, 0);
    chk_rdy("ov5", 1, 0);
    @(negedge clk);
    drv0(1, 16'h0402, 5, 0);
    #1 chk("ov6_err", o_err, 1);
    chk_rdy("ov6", 0, 1);
    chk_out("ov6", 1, Y0402, 0, 4);
    @(negedge clk);
    drv1(0, 16'h0, 0, 0);
    #1 chk_out("ov7", 1, Y2010, 1, 14);
    chk_rdy("ov7", 1, 0);
    @(negedge clk);
    drv0(1, 16'h0402, 6, 1);
    #1 chk("ov8_err", o_err, 1);
    chk_rdy("ov8", 1, 0);
    chk_out("ov8", 1, Y0402, 0, 5);
    @(negedge clk);

    // Async reset in the middle of an r1 burst
    drv0(0, 16'h0, 0, 0);
    drv1(1, 16'h8001, 15, 0);
    #1 chk("ar1_err", o_err, 1);
    chk_rdy("ar1", 0, 1);
    @(negedge clk);
    drv0(1, 16'h0402, 9, 1);
    drv1(1, 16'h8001, 0, 0);
    #1 chk_rdy("ar2", 0, 1);
    chk_out("ar2", 1, Y8001, 1, 15);
    @(negedge clk);
    drv1(1, 16'h2010, 10, 1);
    #1 chk_out("ar3", 1, Y8001, 1, 0);
    rst_n = 1'b0;
    #1 chk_out("ar_rst", 0, 16'h0, 0, 0);
    chk("ar_rst_err", o_err, 0);
    chk_rdy("ar_rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_rdy("ar4", 1, 0);
    @(negedge clk);
    drv0(0, 16'h0, 0, 0);
    drv1(0, 16'h0, 0, 0);
    #1 chk_out("ar5", 1, Y0402, 0, 9);
    chk("ar5_err", o_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
